rf_sweep_sb: RTL and testbench
==============================

Name: rf_sweep_sb

Overview:
- Parametrised register file that replaces the fixed 32x32 two-read/one-write file in the multicycle core.
- Clears its contents with a post-reset sweep FSM instead of a simulation-only initial block, so clearing is synthesizable.
- Adds optional write-to-read bypass, a configurable hardwired-zero register and an optional scoreboard of pending writes.
- Sits between the decode/operand-fetch stage and the writeback mux.

Parameters:
DATA_W, 32, width of each register
ADDR_W, 5, address width; DEPTH = 2**ADDR_W entries
ZERO_REG, 1, 1 = entry 0 reads as 0 and ignores writes; 0 = entry 0 is an ordinary register
BYPASS, 0, 1 = a read in the same cycle as a write to that address returns the write data

Ports:
clk  in  1  clock; all state updates on rising edge
rst_n  in  1  asynchronous active-low reset
ready  out  1  1 once the clear sweep is done; 0 during INIT
ra1  in  ADDR_W  read address, port 1
ra2  in  ADDR_W  read address, port 2
rd1  out  DATA_W  read data, port 1 (combinational)
rd2  out  DATA_W  read data, port 2 (combinational)
we  in  1  write enable
wa  in  ADDR_W  write address
wd  in  DATA_W  write data
sb_set  in  1  mark register sb_a as pending (scoreboard build only)
sb_a  in  ADDR_W  address to mark pending (scoreboard build only)
busy1  out  1  pending flag for ra1 (scoreboard build only)
busy2  out  1  pending flag for ra2 (scoreboard build only)

Behaviour:
- FSM states INIT and READY; a sweep counter of ADDR_W bits.
- Reset (rst_n low, asynchronous): state = INIT, counter = 0, ready = 0, all scoreboard bits = 0. Array contents are not reset directly.
- INIT:
  - Each cycle writes 0 to entry[counter] and increments the counter.
  - When counter == DEPTH-1, that last entry is cleared and the FSM moves to READY. This takes exactly DEPTH cycles after rst_n rises.
  - ready rises on the edge that enters READY.
  - During INIT: rd1 = rd2 = 0, we is ignored, sb_set is ignored, busy1 = busy2 = 0.
- Reset asserted mid-sweep or mid-operation: immediate return to INIT with counter 0; a full DEPTH-cycle sweep runs again.
- READY write: if we is high, entry[wa] <= wd on the clock edge. If ZERO_REG = 1 and wa == 0, the write is discarded.
- READY read: rdN = entry[raN], with zero-cycle latency.
  - ZERO_REG = 1 and raN == 0 gives rdN = 0.
  - BYPASS = 1, we = 1, wa == raN, and the write is not discarded gives rdN = wd in the same cycle.
  - BYPASS = 0 returns the old value until the next cycle.
- Both read ports are independent. ra1 == ra2 is legal and both return the same data.
- FSM never leaves READY except on reset. The counter holds at DEPTH-1 and does not wrap.

Optional Feature:
Macro RF_SCOREBOARD_EN.
- Defined:
  - DEPTH pending bits are implemented.
  - sb_set marks sb_a pending on the clock edge. A non-discarded we clears pending[wa] on the clock edge.
  - If sb_set and we target the same address in the same cycle, set wins: the bit stays 1, because a new producer was issued.
  - busyN = pending[raN], combinational.
  - With ZERO_REG = 1, entry 0 is never pending.
  - BYPASS = 1 and a clearing write to raN in the current cycle gives busyN = 0 in that same cycle.
- Undefined: sb_set, sb_a, busy1 and busy2 are removed from the port list and no pending state is built.

Test Plan:
- Sweep: release rst_n, DEPTH=32 -> ready = 0 for 32 cycles and 1 from the 32nd edge; after that, all 32 reads return 0x00000000.
- Write/read and R0: we=1, wa=5, wd=0xDEADBEEF, then ra1=5 -> rd1 = 0xDEADBEEF one cycle later. we=1, wa=0, wd=0x1234 -> rd2 with ra2=0 = 0.
- Bypass: BYPASS=1, we=1, wa=7, wd=0xA5A5A5A5, ra1=7 in the same cycle -> rd1 = 0xA5A5A5A5 that cycle. BYPASS=0 -> rd1 = the old value, and the new value the next cycle.
- Reset mid-sweep: pulse rst_n low at sweep cycle 10 -> ready stays 0 for 32 cycles after release. Writes issued during INIT leave the targets at 0.
- Scoreboard (RF_SCOREBOARD_EN): sb_set at 3 -> busy1 = 1 for ra1=3; we at 3 -> busy1 = 0 next cycle. sb_set and we both at 3 in one cycle -> busy1 stays 1.
- Reset after data: write 0x55 to r9, assert rst_n low -> ready = 0, and r9 reads 0 after the sweep completes.

Source files
------------

// File: rtl/rf_sweep_sb_if.sv
// Register-file bus bundle: read/write ports, ready flag and, when
// RF_SCOREBOARD_EN is defined, the pending-write scoreboard signals.
interface rf_sweep_sb_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
);
    logic              ready;
    logic [ADDR_W-1:0] ra1;
    logic [ADDR_W-1:0] ra2;
    logic [DATA_W-1:0] rd1;
    logic [DATA_W-1:0] rd2;
    logic              we;
    logic [ADDR_W-1:0] wa;
    logic [DATA_W-1:0] wd;
`ifdef RF_SCOREBOARD_EN
    logic              sb_set;
    logic [ADDR_W-1:0] sb_a;
    logic              busy1;
    logic              busy2;

    modport master (
        input  ready, rd1, rd2, busy1, busy2,
        output ra1, ra2, we, wa, wd, sb_set, sb_a
    );

    modport slave (
        output ready, rd1, rd2, busy1, busy2,
        input  ra1, ra2, we, wa, wd, sb_set, sb_a
    );
`else
    modport master (
        input  ready, rd1, rd2,
        output ra1, ra2, we, wa, wd
    );

    modport slave (
        output ready, rd1, rd2,
        input  ra1, ra2, we, wa, wd
    );
`endif
endinterface

// File: rtl/rf_sweep_sb.sv
// Two-read/one-write register file cleared by a post-reset sweep, with optional
// hardwired zero entry, write-to-read bypass and (RF_SCOREBOARD_EN) a pending-write scoreboard.
module rf_sweep_sb #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 0
) (
    input  logic          clk,
    input  logic          rst_n,
    rf_sweep_sb_if.slave  io_rf
);
    localparam int              DEPTH    = 32'sd1 << ADDR_W;
    localparam logic [ADDR_W-1:0] CNT_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] CNT_LAST = {ADDR_W{1'b1}};
    localparam logic [ADDR_W-1:0] ADDR_Z   = {ADDR_W{1'b0}};
    localparam logic [DATA_W-1:0] DATA_Z   = {DATA_W{1'b0}};
    localparam logic              ZR       = (ZERO_REG != 32'sd0);
    localparam logic              BYP      = (BYPASS != 32'sd0);

    typedef enum logic [0:0] {
        ST_INIT  = 1'b0,
        ST_READY = 1'b1
    } state_t;

    state_t            r_state;
    logic [ADDR_W-1:0] r_cnt;
    logic              r_ready;
    logic [DATA_W-1:0] r_mem [DEPTH];

    logic              w_wr_ok;
    logic [DATA_W-1:0] w_rd1;
    logic [DATA_W-1:0] w_rd2;

    // A write lands only once the sweep is done and never into a hardwired-zero entry.
    always_comb begin
        w_wr_ok = 1'b0;
        if ((r_state == ST_READY) && io_rf.we && !(ZR && (io_rf.wa == ADDR_Z))) begin
            w_wr_ok = 1'b1;
        end else begin
            w_wr_ok = 1'b0;
        end
    end

    // Sweep sequencer: walks every entry once after reset, then parks in READY.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_INIT;
            r_cnt   <= ADDR_Z;
            r_ready <= 1'b0;
        end else begin
            case (r_state)
                ST_INIT: begin
                    if (r_cnt == CNT_LAST) begin
                        r_state <= ST_READY;
                        r_ready <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + CNT_ONE;
                    end
                end
                ST_READY: begin
                    r_state <= ST_READY;
                    r_ready <= 1'b1;
                end
                default: begin
                    r_state <= ST_INIT;
                    r_cnt   <= ADDR_Z;
                    r_ready <= 1'b0;
                end
            endcase
        end
    end

    // Storage array: the sweep owns the write port during INIT, normal writes afterwards.
    always_ff @(posedge clk) begin
        if (r_state == ST_INIT) begin
            r_mem[r_cnt] <= DATA_Z;
        end else if (w_wr_ok) begin
            r_mem[io_rf.wa] <= io_rf.wd;
        end
    end

    // Read port 1: zero while sweeping, then zero-reg, bypass, array in priority order.
    always_comb begin
        w_rd1 = DATA_Z;
        if (r_state != ST_READY) begin
            w_rd1 = DATA_Z;
        end else if (ZR && (io_rf.ra1 == ADDR_Z)) begin
            w_rd1 = DATA_Z;
        end else if (BYP && w_wr_ok && (io_rf.wa == io_rf.ra1)) begin
            w_rd1 = io_rf.wd;
        end else begin
            w_rd1 = r_mem[io_rf.ra1];
        end
    end

    // Read port 2: identical selection, independent address.
    always_comb begin
        w_rd2 = DATA_Z;
        if (r_state != ST_READY) begin
            w_rd2 = DATA_Z;
        end else if (ZR && (io_rf.ra2 == ADDR_Z)) begin
            w_rd2 = DATA_Z;
        end else if (BYP && w_wr_ok && (io_rf.wa == io_rf.ra2)) begin
            w_rd2 = io_rf.wd;
        end else begin
            w_rd2 = r_mem[io_rf.ra2];
        end
    end

    assign io_rf.ready = r_ready;
    assign io_rf.rd1   = w_rd1;
    assign io_rf.rd2   = w_rd2;

`ifdef RF_SCOREBOARD_EN
    logic [DEPTH-1:0] r_pending;
    logic             w_sb_ok;
    logic             w_wr_clr;
    logic             w_busy1;
    logic             w_busy2;

    // A same-cycle set to the written address means a newer producer, so it is not a clear.
    always_comb begin
        w_sb_ok  = 1'b0;
        w_wr_clr = 1'b0;
        if ((r_state == ST_READY) && io_rf.sb_set && !(ZR && (io_rf.sb_a == ADDR_Z))) begin
            w_sb_ok = 1'b1;
        end else begin
            w_sb_ok = 1'b0;
        end
        if (w_wr_ok && !(w_sb_ok && (io_rf.sb_a == io_rf.wa))) begin
            w_wr_clr = 1'b1;
        end else begin
            w_wr_clr = 1'b0;
        end
    end

    // Pending bits: clear on write, then set, so a simultaneous set wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pending <= {DEPTH{1'b0}};
        end else begin
            if (w_wr_ok) begin
                r_pending[io_rf.wa] <= 1'b0;
            end
            if (w_sb_ok) begin
                r_pending[io_rf.sb_a] <= 1'b1;
            end
        end
    end

    // Busy flags follow the read addresses; a bypassed clearing write hides the flag early.
    always_comb begin
        w_busy1 = 1'b0;
        w_busy2 = 1'b0;
        if (r_state != ST_READY) begin
            w_busy1 = 1'b0;
        end else if (BYP && w_wr_clr && (io_rf.wa == io_rf.ra1)) begin
            w_busy1 = 1'b0;
        end else begin
            w_busy1 = r_pending[io_rf.ra1];
        end
        if (r_state != ST_READY) begin
            w_busy2 = 1'b0;
        end else if (BYP && w_wr_clr && (io_rf.wa == io_rf.ra2)) begin
            w_busy2 = 1'b0;
        end else begin
            w_busy2 = r_pending[io_rf.ra2];
        end
    end

    assign io_rf.busy1 = w_busy1;
    assign io_rf.busy2 = w_busy2;
`endif

endmodule

// File: tb/tb_rf_sweep_sb.sv
// Randomised self-checking bench for rf_sweep_sb: two instances (zero-reg/no-bypass and
// plain-r0/bypass) driven identically and compared with an array-based reference model.
module tb_rf_sweep_sb;
    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    int n_total = 0;
    int n_bad   = 0;

    always #5 clk = ~clk;

    rf_sweep_sb_if #(.ADDR_W(5), .DATA_W(32)) bus_a ();
    rf_sweep_sb_if #(.ADDR_W(5), .DATA_W(32)) bus_b ();

    rf_sweep_sb #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1), .BYPASS(0)) u_dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .io_rf (bus_a)
    );

    rf_sweep_sb #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(0), .BYPASS(1)) u_dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .io_rf (bus_b)
    );

    // Reference model: index 0 models u_dut_a, index 1 models u_dut_b.
    bit          zr  [2] = '{1'b1, 1'b0};
    bit          byp [2] = '{1'b0, 1'b1};
    logic [31:0] mdl [2][32];
    bit          pend [2][32];
    bit          exp_ready = 1'b0;
    int          sweep_cnt = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] exp_rd(int k, logic [4:0] ra, logic we, logic [4:0] wa,
                                           logic [31:0] wd);
        if (!exp_ready) return 32'h0;
        if (zr[k] && ra == 5'd0) return 32'h0;
        if (byp[k] && we && wa == ra && !(zr[k] && wa == 5'd0)) return wd;
        return mdl[k][ra];
    endfunction

    function automatic logic exp_busy(int k, logic [4:0] ra, logic we, logic [4:0] wa,
                                      logic sbs, logic [4:0] sba);
        bit sb_ok;
        bit wr_ok;
        if (!exp_ready) return 1'b0;
        sb_ok = sbs && !(zr[k] && sba == 5'd0);
        wr_ok = we && !(zr[k] && wa == 5'd0);
        if (byp[k] && wr_ok && wa == ra && !(sb_ok && sba == wa)) return 1'b0;
        return pend[k][ra];
    endfunction

    task automatic model_reset();
        exp_ready = 1'b0;
        sweep_cnt = 0;
        for (int k = 0; k < 2; k++)
            for (int a = 0; a < 32; a++) pend[k][a] = 1'b0;
    endtask

    // One clock cycle: drive at negedge, check combinational reads, advance model at posedge, check ready.
    task automatic step(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                        input logic [4:0] ra1, input logic [4:0] ra2,
                        input logic sbs, input logic [4:0] sba);
        @(negedge clk);
        bus_a.we = we;  bus_a.wa = wa;  bus_a.wd = wd;  bus_a.ra1 = ra1;  bus_a.ra2 = ra2;
        bus_b.we = we;  bus_b.wa = wa;  bus_b.wd = wd;  bus_b.ra1 = ra1;  bus_b.ra2 = ra2;
`ifdef RF_SCOREBOARD_EN
        bus_a.sb_set = sbs;  bus_a.sb_a = sba;
        bus_b.sb_set = sbs;  bus_b.sb_a = sba;
`endif
        #1;
        check_val("rd1_a", bus_a.rd1, exp_rd(0, ra1, we, wa, wd));
        check_val("rd2_a", bus_a.rd2, exp_rd(0, ra2, we, wa, wd));
        check_val("rd1_b", bus_b.rd1, exp_rd(1, ra1, we, wa, wd));
        check_val("rd2_b", bus_b.rd2, exp_rd(1, ra2, we, wa, wd));
`ifdef RF_SCOREBOARD_EN
        check_val("busy1_a", {31'd0, bus_a.busy1}, {31'd0, exp_busy(0, ra1, we, wa, sbs, sba)});
        check_val("busy2_a", {31'd0, bus_a.busy2}, {31'd0, exp_busy(0, ra2, we, wa, sbs, sba)});
        check_val("busy1_b", {31'd0, bus_b.busy1}, {31'd0, exp_busy(1, ra1, we, wa, sbs, sba)});
        check_val("busy2_b", {31'd0, bus_b.busy2}, {31'd0, exp_busy(1, ra2, we, wa, sbs, sba)});
`endif
        @(posedge clk);
        if (rst_n) begin
            if (exp_ready) begin
                for (int k = 0; k < 2; k++) begin
                    bit wr_ok;
                    bit sb_ok;
                    wr_ok = we && !(zr[k] && wa == 5'd0);
                    sb_ok = sbs && !(zr[k] && sba == 5'd0);
                    if (wr_ok) begin
                        mdl[k][wa]  = wd;
                        pend[k][wa] = 1'b0;
                    end
`ifdef RF_SCOREBOARD_EN
                    if (sb_ok) pend[k][sba] = 1'b1;
`else
                    if (sb_ok) pend[k][sba] = 1'b0;
`endif
                end
            end else begin
                sweep_cnt++;
                if (sweep_cnt == 32) begin
                    exp_ready = 1'b1;
                    for (int k = 0; k < 2; k++)
                        for (int a = 0; a < 32; a++) mdl[k][a] = 32'h0;
                end
            end
        end
        #1;
        check_val("ready_a", {31'd0, bus_a.ready}, {31'd0, exp_ready});
        check_val("ready_b", {31'd0, bus_b.ready}, {31'd0, exp_ready});
    endtask

    task automatic idle(input logic [4:0] ra1, input logic [4:0] ra2);
        step(1'b0, 5'd0, 32'h0, ra1, ra2, 1'b0, 5'd0);
    endtask

    // Asynchronous reset pulse applied mid-cycle, released away from the clock edge.
    task automatic apply_reset();
        #1;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_val("ready_rst_a", {31'd0, bus_a.ready}, 32'd0);
        check_val("ready_rst_b", {31'd0, bus_b.ready}, 32'd0);
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    initial begin
        logic [4:0]  wa;
        logic [4:0]  ra1;
        logic [4:0]  ra2;
        logic [4:0]  sba;
        bus_a.we = 1'b0;  bus_a.wa = 5'd0;  bus_a.wd = 32'h0;  bus_a.ra1 = 5'd0;  bus_a.ra2 = 5'd0;
        bus_b.we = 1'b0;  bus_b.wa = 5'd0;  bus_b.wd = 32'h0;  bus_b.ra1 = 5'd0;  bus_b.ra2 = 5'd0;
`ifdef RF_SCOREBOARD_EN
        bus_a.sb_set = 1'b0;  bus_a.sb_a = 5'd0;
        bus_b.sb_set = 1'b0;  bus_b.sb_a = 5'd0;
`endif
        apply_reset();

        // Sweep with write attempts that must be ignored, then every entry reads zero.
        for (int i = 0; i < 32; i++) step(1'b1, 5'(i), $urandom, 5'(i), 5'(31 - i), 1'b1, 5'(i));
        for (int i = 0; i < 32; i++) idle(5'(i), 5'(31 - i));

        // Directed write/read, hardwired zero and bypass.
        step(1'b1, 5'd5, 32'hDEADBEEF, 5'd5, 5'd1, 1'b0, 5'd0);
        idle(5'd5, 5'd5);
        step(1'b1, 5'd0, 32'h00001234, 5'd1, 5'd0, 1'b0, 5'd0);
        idle(5'd0, 5'd0);
        step(1'b1, 5'd7, 32'h11111111, 5'd1, 5'd2, 1'b0, 5'd0);
        step(1'b1, 5'd7, 32'hA5A5A5A5, 5'd7, 5'd7, 1'b0, 5'd0);
        idle(5'd7, 5'd5);

        // Scoreboard: set, clear, and set-beats-clear on the same address.
        step(1'b0, 5'd0, 32'h0, 5'd3, 5'd4, 1'b1, 5'd3);
        idle(5'd3, 5'd3);
        step(1'b1, 5'd3, 32'h33, 5'd3, 5'd3, 1'b0, 5'd0);
        idle(5'd3, 5'd3);
        step(1'b1, 5'd3, 32'h34, 5'd3, 5'd3, 1'b1, 5'd3);
        idle(5'd3, 5'd3);
        step(1'b0, 5'd0, 32'h0, 5'd0, 5'd3, 1'b1, 5'd0);
        idle(5'd0, 5'd0);

        // Randomised traffic with address collisions biased in.
        for (int i = 0; i < 600; i++) begin
            wa  = ($urandom_range(0, 4) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
            ra1 = ($urandom_range(0, 2) == 0) ? wa : 5'($urandom_range(0, 31));
            ra2 = ($urandom_range(0, 2) == 0) ? wa : 5'($urandom_range(0, 31));
            sba = ($urandom_range(0, 2) == 0) ? wa : 5'($urandom_range(0, 31));
            step(1'($urandom_range(0, 1)), wa, $urandom, ra1, ra2,
                 1'($urandom_range(0, 3) == 0), sba);
        end

        // Reset mid-sweep at cycle 10; writes during the new sweep must not stick.
        apply_reset();
        for (int i = 0; i < 10; i++) idle(5'd9, 5'd12);
        apply_reset();
        for (int i = 0; i < 32; i++) step(1'b1, 5'd12, 32'hCAFE0000 + 32'(i), 5'd12, 5'd9, 1'b1, 5'd12);
        idle(5'd12, 5'd9);

        // Data present before reset is gone after the sweep.
        step(1'b1, 5'd9, 32'h00000055, 5'd9, 5'd9, 1'b0, 5'd0);
        idle(5'd9, 5'd9);
        apply_reset();
        for (int i = 0; i < 32; i++) idle(5'd9, 5'd9);
        idle(5'd9, 5'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
